probatina_example_vadd_scheduler: RTL and testbench

- Job sequencer in front of the vadd kernel datapath (read master -> adder -> write master).
- Accepts one job descriptor at a time: base address, total byte count, adder constant.
- Splits the job into fixed-size chunks and issues one ap_start per chunk. Waits for ap_done before issuing the next chunk.
- Reports job completion, chunk progress and watchdog errors to the control logic.

---
 rtl/probatina_example_vadd_scheduler.sv | 137 +++++++++++++
 tb/tb_probatina_example_vadd_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/probatina_example_vadd_scheduler.sv
// Job sequencer for the vadd kernel: splits one job into fixed-size
// chunks and drives one ap_start per chunk, with a WAIT watchdog.
module probatina_example_vadd_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = 4096,
  parameter int C_TIMEOUT_WIDTH    = 20
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_job_valid,
  output logic                          s_job_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s_job_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  s_job_size,
  input  logic [C_ADDER_BIT_WIDTH-1:0]  s_job_constant,
  output logic                          ap_start,
  input  logic                          ap_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant,
  output logic                          busy,
  output logic [C_XFER_SIZE_WIDTH-1:0]  chunk_count,
  output logic                          job_done,
  output logic                          job_err
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int TW = C_TIMEOUT_WIDTH;

  localparam logic [XW-1:0] CHUNK  = XW'(C_CHUNK_BYTES);
  localparam logic [AW-1:0] STEP   = AW'(C_CHUNK_BYTES);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  // last watchdog value before it would reach all-ones
  localparam logic [TW-1:0] T_LAST = T_MAX - T_ONE;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] remaining;
  logic [XW-1:0] rem_next;
  logic [TW-1:0] wd;

  function automatic logic [XW-1:0] clip(
    input logic [XW-1:0] n
  );
    return (n > CHUNK) ? CHUNK : n;
  endfunction

  assign rem_next = remaining - ctrl_xfer_size_in_bytes;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                   <= IDLE;
      s_job_ready             <= 1'b0;
      ap_start                <= 1'b0;
      busy                    <= 1'b0;
      job_done                <= 1'b0;
      job_err                 <= 1'b0;
      chunk_count             <= '0;
      ctrl_addr_offset        <= '0;
      ctrl_xfer_size_in_bytes <= '0;
      ctrl_constant           <= '0;
      remaining               <= '0;
      wd                      <= '0;
    end else begin
      ap_start <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          s_job_ready <= 1'b1;
          busy        <= 1'b0;
          job_err     <= 1'b0;
          if (s_job_valid && s_job_ready) begin
            s_job_ready             <= 1'b0;
            busy                    <= 1'b1;
            ctrl_addr_offset        <= s_job_addr;
            ctrl_xfer_size_in_bytes <= clip(s_job_size);
            ctrl_constant           <= s_job_constant;
            remaining               <= s_job_size;
            chunk_count             <= '0;
            if (s_job_size == '0) begin
              state    <= DONE;
              job_done <= 1'b1;
            end else begin
              state    <= START;
              ap_start <= 1'b1;
            end
          end
        end
        START: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // ap_done takes priority over a watchdog expiry in the same cycle
          if (ap_done) begin
            remaining               <= rem_next;
            chunk_count             <= chunk_count + X_ONE;
            ctrl_addr_offset        <= ctrl_addr_offset + STEP;
            ctrl_xfer_size_in_bytes <= clip(rem_next);
            if (rem_next == '0) begin
              state    <= DONE;
              job_done <= 1'b1;
            end else begin
              state    <= START;
              ap_start <= 1'b1;
            end
          end else if (wd == T_LAST) begin
            wd       <= wd + T_ONE;
            state    <= DONE;
            job_done <= 1'b1;
            job_err  <= 1'b1;
          end else begin
            wd <= wd + T_ONE;
          end
        end
        DONE: begin
          state       <= IDLE;
          s_job_ready <= 1'b1;
          busy        <= 1'b0;
          job_err     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probatina_example_vadd_scheduler.sv
// Bench for the vadd job scheduler: directed plan plus random jobs
// checked against an arithmetic chunk model.
module tb_probatina_example_vadd_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_job_valid;
  logic        s_job_ready;
  logic [63:0] s_job_addr;
  logic [31:0] s_job_size;
  logic [31:0] s_job_constant;
  logic        ap_start;
  logic        ap_done;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic [31:0] ctrl_constant;
  logic        busy;
  logic [31:0] chunk_count;
  logic        job_done;
  logic        job_err;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  probatina_example_vadd_scheduler #(
    .C_TIMEOUT_WIDTH(4)
  ) dut (
    .aclk                    (aclk),
    .aresetn                 (aresetn),
    .s_job_valid             (s_job_valid),
    .s_job_ready             (s_job_ready),
    .s_job_addr              (s_job_addr),
    .s_job_size              (s_job_size),
    .s_job_constant          (s_job_constant),
    .ap_start                (ap_start),
    .ap_done                 (ap_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_constant           (ctrl_constant),
    .busy                    (busy),
    .chunk_count             (chunk_count),
    .job_done                (job_done),
    .job_err                 (job_err)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, s_job_ready, 0);
    check({tag, ".start"}, ap_start, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, job_done, 0);
    check({tag, ".err"}, job_err, 0);
    check({tag, ".cnt"}, chunk_count, 0);
    check({tag, ".addr"}, ctrl_addr_offset, 0);
    check({tag, ".size"}, ctrl_xfer_size_in_bytes, 0);
    check({tag, ".const"}, ctrl_constant, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && s_job_ready !== 1'b1; i++)
      @(negedge aclk);
    check("ready_wait", s_job_ready, 1);
  endtask

  // Run one job; model: chunk i at a+i*4096, size min(s-i*4096, 4096)
  task automatic do_job(input logic [63:0] a, input logic [31:0] s,
                        input logic [31:0] k, input int maxd,
                        input bit hold, input bit spur);
    int n;
    int d;
    logic [63:0] ea;
    logic [31:0] rem;
    logic [31:0] es;
    wait_ready();
    s_job_addr     = a;
    s_job_size     = s;
    s_job_constant = k;
    s_job_valid    = 1'b1;
    @(negedge aclk);
    if (!hold) s_job_valid = 1'b0;
    n = int'((64'(s) + 64'd4095) / 64'd4096);
    check("busy", busy, 1);
    check("ready_low", s_job_ready, 0);
    if (n == 0) begin
      check("zero.done", job_done, 1);
      check("zero.err", job_err, 0);
      check("zero.start", ap_start, 0);
      check("zero.cnt", chunk_count, 0);
    end
    for (int i = 0; i < n; i++) begin
      ea  = a + 64'(i) * 64'd4096;
      rem = s - 32'(i) * 32'd4096;
      es  = (rem > 32'd4096) ? 32'd4096 : rem;
      check("start", ap_start, 1);
      check("addr", ctrl_addr_offset, ea);
      check("size", ctrl_xfer_size_in_bytes, es);
      check("const", ctrl_constant, k);
      check("cnt_pre", chunk_count, 64'(i));
      if (spur && i == 0) ap_done = 1'b1;
      @(negedge aclk);
      ap_done = 1'b0;
      check("start_pulse", ap_start, 0);
      check("cnt_spur", chunk_count, 64'(i));
      d = $urandom_range(maxd, 0);
      repeat (d) begin
        check("hold_addr", ctrl_addr_offset, ea);
        check("hold_size", ctrl_xfer_size_in_bytes, es);
        if (hold) check("ready_held", s_job_ready, 0);
        @(negedge aclk);
      end
      ap_done = 1'b1;
      @(negedge aclk);
      ap_done = 1'b0;
      check("cnt_post", chunk_count, 64'(i + 1));
    end
    if (n > 0) begin
      check("done", job_done, 1);
      check("err", job_err, 0);
      check("start_at_done", ap_start, 0);
    end
  endtask

  initial begin
    int cnt;
    logic [63:0] ra;
    logic [31:0] rs;
    aresetn        = 1'b0;
    s_job_valid    = 1'b0;
    s_job_addr     = '0;
    s_job_size     = '0;
    s_job_constant = '0;
    ap_done        = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    do_job(64'h1000, 32'd10000, 32'd5, 3, 1'b0, 1'b0);
    check("chunked.cnt", chunk_count, 3);
    do_job(64'h8000, 32'd0, 32'd7, 2, 1'b0, 1'b0);
    do_job(64'h4000, 32'd4096, 32'd9, 2, 1'b0, 1'b0);
    check("exact.cnt", chunk_count, 1);

    // watchdog: ap_done never arrives
    wait_ready();
    s_job_addr  = 64'hA000;
    s_job_size  = 32'd100;
    s_job_valid = 1'b1;
    @(negedge aclk);
    s_job_valid = 1'b0;
    check("wd.start", ap_start, 1);
    cnt = 0;
    while (cnt < 40 && job_done !== 1'b1) begin
      @(negedge aclk);
      cnt++;
    end
    check("wd.latency", cnt, 16);
    check("wd.err", job_err, 1);
    check("wd.cnt", chunk_count, 0);
    @(negedge aclk);
    check("wd.ready", s_job_ready, 1);
    check("wd.err_clr", job_err, 0);
    check("wd.done_clr", job_done, 0);
    do_job(64'hB000, 32'd5000, 32'd11, 4, 1'b0, 1'b0);

    // valid held across a job, spurious done in START, then next job
    do_job(64'h9000, 32'd8292, 32'd3, 2, 1'b1, 1'b1);
    do_job(64'hC000, 32'd300, 32'd4, 2, 1'b0, 1'b0);

    // spurious done while idle
    @(negedge aclk);
    ap_done = 1'b1;
    @(negedge aclk);
    ap_done = 1'b0;
    @(negedge aclk);
    check("idle_spur.cnt", chunk_count, 1);
    check("idle_spur.busy", busy, 0);
    check("idle_spur.start", ap_start, 0);
    check("idle_spur.ready", s_job_ready, 1);

    // reset in the WAIT of chunk 2
    wait_ready();
    s_job_addr     = 64'h5000;
    s_job_size     = 32'd12000;
    s_job_constant = 32'd2;
    s_job_valid    = 1'b1;
    @(negedge aclk);
    s_job_valid = 1'b0;
    check("mr.start1", ap_start, 1);
    repeat (3) @(negedge aclk);
    ap_done = 1'b1;
    @(negedge aclk);
    ap_done = 1'b0;
    check("mr.start2", ap_start, 1);
    check("mr.addr2", ctrl_addr_offset, 64'h6000);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge aclk);
    check("mr.nodone", job_done, 0);
    aresetn = 1'b1;
    do_job(64'h7000, 32'd9000, 32'd6, 3, 1'b0, 1'b0);

    // random jobs, including an address that wraps
    do_job(64'hFFFF_FFFF_FFFF_F000, 32'd9000, 32'd1, 3, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      ra = {$urandom, $urandom};
      rs = $urandom_range(20000, 0);
      do_job(ra, rs, $urandom, 6, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
